// File: rtl/score_timer_bcd.sv
// score_timer_bcd
// Game-state core for whack-a-mole. It holds the player score and the
// countdown timer as two-digit packed BCD and feeds them straight to the
// 7-segment multiplexer. A prescaler divides the 1 kHz scan clock down
// to one game second.
module score_timer_bcd #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int GAME_SECONDS  = 30
) (
  input  logic       clk_1k,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [7:0] score_bcd,
  output logic [7:0] time_bcd,
  output logic       game_active,
  output logic       game_over
);

  // Round length in BCD, computed once at elaboration.
  localparam logic [7:0]  TimeInit = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};
  // Last prescaler count before it wraps and a game second elapses.
  localparam logic [15:0] PreMax   = 16'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  time_q, time_d;
  logic [15:0] prescale_q, prescale_d;
  logic        active_q, active_d;
  logic        over_q, over_d;
  logic        startPrev_q, hitPrev_q, missPrev_q;

  logic        startEdge, hitEdge, missEdge;

  // BCD increment that saturates at 99; a ones digit of 9 carries into the tens.
  function automatic logic [7:0] bcdInc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD decrement that floors at 00; a ones digit of 0 borrows from the tens.
  function automatic logic [7:0] bcdDec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = v;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Rising-edge pulses. The previous-sample registers come out of reset at 1,
  // so a button held down through reset does not register as a press.
  assign startEdge = start & ~startPrev_q;
  assign hitEdge   = hit   & ~hitPrev_q;
  assign missEdge  = miss  & ~missPrev_q;

  // Capture the previous level of each button for edge detection.
  always_ff @(posedge clk_1k) begin
    if (!rst_n) begin
      startPrev_q <= 1'b1;
      hitPrev_q   <= 1'b1;
      missPrev_q  <= 1'b1;
    end else begin
      startPrev_q <= start;
      hitPrev_q   <= hit;
      missPrev_q  <= miss;
    end
  end

  // Next-state logic for the round FSM, the timer, the prescaler and the score.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    time_d     = time_q;
    prescale_d = prescale_q;

    case (state_q)
      IDLE, OVER: begin
        if (startEdge) begin
          state_d    = RUN;
          score_d    = 8'h00;
          time_d     = TimeInit;
          prescale_d = 16'd0;
        end
      end

      RUN: begin
        if (prescale_q == PreMax) begin
          prescale_d = 16'd0;
          time_d     = bcdDec(time_q);
          if (time_q == 8'h01) begin
            state_d = OVER;
          end
        end else begin
          prescale_d = prescale_q + 16'd1;
        end

        if (hitEdge && !missEdge) begin
          score_d = bcdInc(score_q);
        end else if (missEdge && !hitEdge) begin
          score_d = bcdDec(score_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they change on the same
  // edge as the state register.
  always_comb begin
    active_d = (state_d == RUN);
    over_d   = (state_d == OVER);
  end

  // State, counters and status flags; reset returns to IDLE from anywhere.
  always_ff @(posedge clk_1k) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      score_q    <= 8'h00;
      time_q     <= TimeInit;
      prescale_q <= 16'd0;
      active_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      time_q     <= time_d;
      prescale_q <= prescale_d;
      active_q   <= active_d;
      over_q     <= over_d;
    end
  end

  assign score_bcd   = score_q;
  assign time_bcd    = time_q;
  assign game_active = active_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_score_timer_bcd.sv
// tb_score_timer_bcd
// Directed bench. The main instance uses a 4-tick second and a 12 s round.
// A second instance with a 99 s round gives enough time to reach score saturation.
module tb_score_timer_bcd;

  logic       clk_1k;
  logic       rst_n;
  logic       start;
  logic       hit;
  logic       miss;
  logic [7:0] score_bcd, time_bcd;
  logic       game_active, game_over;
  logic [7:0] score2_bcd, time2_bcd;
  logic       game2_active, game2_over;

  int errors = 0;
  int checks = 0;

  score_timer_bcd #(.TICKS_PER_SEC(4), .GAME_SECONDS(12)) dut (
    .clk_1k      (clk_1k),
    .rst_n       (rst_n),
    .start       (start),
    .hit         (hit),
    .miss        (miss),
    .score_bcd   (score_bcd),
    .time_bcd    (time_bcd),
    .game_active (game_active),
    .game_over   (game_over)
  );

  score_timer_bcd #(.TICKS_PER_SEC(16), .GAME_SECONDS(99)) dut2 (
    .clk_1k      (clk_1k),
    .rst_n       (rst_n),
    .start       (start),
    .hit         (hit),
    .miss        (miss),
    .score_bcd   (score2_bcd),
    .time_bcd    (time2_bcd),
    .game_active (game2_active),
    .game_over   (game2_over)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk_1k = 1'b0;
    forever #5 clk_1k = ~clk_1k;
  end

  // Drive all inputs at once, away from the active edge.
  task automatic applyStimulus(input logic r, input logic s, input logic h, input logic m);
    rst_n = r;
    start = s;
    hit   = h;
    miss  = m;
  endtask

  // Advance n rising edges, settling 1 unit after each.
  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1k);
      #1;
    end
  endtask

  // One immediate-assertion comparison point.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single button pulse: high for one edge, low for one edge.
  task automatic pulseHit();
    hit = 1'b1;
    tickN(1);
    hit = 1'b0;
    tickN(1);
  endtask

  task automatic pulseMiss();
    miss = 1'b1;
    tickN(1);
    miss = 1'b0;
    tickN(1);
  endtask

  initial begin
    $display("[TB] score_timer_bcd directed test");

    // Reset state.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickN(2);
    checkOutput("rst_score", score_bcd, 8'h00);
    checkOutput("rst_time", time_bcd, 8'h12);
    checkOutput("rst_active", {7'd0, game_active}, 8'h00);
    checkOutput("rst_over", {7'd0, game_over}, 8'h00);
    checkOutput("rst_time2", time2_bcd, 8'h99);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tickN(2);
    checkOutput("idle_active", {7'd0, game_active}, 8'h00);

    // Start a round and watch the first seconds, including a tens borrow.
    start = 1'b1;
    tickN(1);
    start = 1'b0;
    checkOutput("start_active", {7'd0, game_active}, 8'h01);
    checkOutput("start_score", score_bcd, 8'h00);
    checkOutput("start_time", time_bcd, 8'h12);
    tickN(3);
    checkOutput("time_pre_tick", time_bcd, 8'h12);
    tickN(1);
    checkOutput("time_11", time_bcd, 8'h11);
    tickN(4);
    checkOutput("time_10", time_bcd, 8'h10);
    tickN(4);
    checkOutput("time_09", time_bcd, 8'h09);

    // Ten separate hits: ones digit wraps into the tens.
    for (int i = 0; i < 10; i++) pulseHit();
    checkOutput("hit10_score", score_bcd, 8'h10);
    checkOutput("hit10_time", time_bcd, 8'h04);

    // Hold hit for 20 cycles: counts once; the round expires meanwhile.
    hit = 1'b1;
    tickN(20);
    hit = 1'b0;
    checkOutput("hold_score", score_bcd, 8'h11);
    checkOutput("expire_time", time_bcd, 8'h00);
    checkOutput("expire_over", {7'd0, game_over}, 8'h01);
    checkOutput("expire_active", {7'd0, game_active}, 8'h00);
    pulseHit();
    pulseHit();
    checkOutput("over_frozen", score_bcd, 8'h11);
    checkOutput("over_time", time_bcd, 8'h00);

    // Restart from OVER.
    start = 1'b1;
    tickN(1);
    start = 1'b0;
    checkOutput("restart_active", {7'd0, game_active}, 8'h01);
    checkOutput("restart_over", {7'd0, game_over}, 8'h00);
    checkOutput("restart_score", score_bcd, 8'h00);
    checkOutput("restart_time", time_bcd, 8'h12);

    // Miss floor at 00.
    pulseHit();
    checkOutput("pre_miss", score_bcd, 8'h01);
    pulseMiss();
    checkOutput("miss_to_00", score_bcd, 8'h00);
    pulseMiss();
    checkOutput("miss_floor", score_bcd, 8'h00);

    // Hit and miss rising together cancel.
    pulseHit();
    hit  = 1'b1;
    miss = 1'b1;
    tickN(1);
    hit  = 1'b0;
    miss = 1'b0;
    tickN(1);
    checkOutput("hit_miss_same", score_bcd, 8'h01);

    // A start pulse during RUN has no effect.
    start = 1'b1;
    tickN(1);
    start = 1'b0;
    tickN(1);
    checkOutput("start_in_run_time", time_bcd, 8'h09);
    checkOutput("start_in_run_score", score_bcd, 8'h01);

    // A hit on the final decrement edge is counted alongside the move to OVER.
    tickN(35);
    checkOutput("final_sec_time", time_bcd, 8'h01);
    checkOutput("final_sec_active", {7'd0, game_active}, 8'h01);
    hit = 1'b1;
    tickN(1);
    hit = 1'b0;
    checkOutput("final_hit_score", score_bcd, 8'h02);
    checkOutput("final_hit_time", time_bcd, 8'h00);
    checkOutput("final_hit_over", {7'd0, game_over}, 8'h01);
    tickN(1);
    pulseHit();
    checkOutput("final_frozen", score_bcd, 8'h02);

    // Mid-round reset at time 07, score 05.
    start = 1'b1;
    tickN(1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) pulseHit();
    tickN(10);
    checkOutput("mid_time", time_bcd, 8'h07);
    checkOutput("mid_score", score_bcd, 8'h05);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tickN(1);
    checkOutput("midrst_score", score_bcd, 8'h00);
    checkOutput("midrst_time", time_bcd, 8'h12);
    checkOutput("midrst_active", {7'd0, game_active}, 8'h00);
    checkOutput("midrst_over", {7'd0, game_over}, 8'h00);
    rst_n = 1'b1;
    tickN(2);
    checkOutput("held_start_no_edge", {7'd0, game_active}, 8'h00);
    start = 1'b0;
    tickN(1);
    start = 1'b1;
    tickN(1);
    start = 1'b0;
    checkOutput("post_rst_active", {7'd0, game_active}, 8'h01);
    tickN(3);
    checkOutput("held_hit_no_edge", score_bcd, 8'h00);
    hit = 1'b0;

    // Saturation on the long-round instance.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tickN(1);
    rst_n = 1'b1;
    tickN(1);
    start = 1'b1;
    tickN(1);
    start = 1'b0;
    checkOutput("sat_start_active", {7'd0, game2_active}, 8'h01);
    for (int i = 0; i < 99; i++) pulseHit();
    checkOutput("sat_99", score2_bcd, 8'h99);
    pulseHit();
    checkOutput("sat_hold_99", score2_bcd, 8'h99);
    pulseMiss();
    checkOutput("sat_miss_98", score2_bcd, 8'h98);
    checkOutput("sat_time", time2_bcd, 8'h87);
    checkOutput("sat_still_run", {7'd0, game2_active}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
